// File: rtl/nfc_pkg.sv
// Shared constants, FSM encoding and request payload for the flash-to-flash copy scheduler.
package nfc_pkg;

  localparam int PAGE_W    = 9;
  localparam int NUM_PAGES = 512;
  localparam int MAX_RETRY = 3;
  localparam int CNT_W     = PAGE_W + 1;
  localparam int RETRY_W   = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH
  } state_e;

  typedef struct packed {
    logic [PAGE_W-1:0] page;
    logic              slot;
  } req_t;

  // Page counters stop at NUM_PAGES so they can never wrap past the end of the device.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_W'(NUM_PAGES)) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nfc_req_port.sv
// Registered req/ack holder for one command engine: latches page/slot on issue, holds req
// until ack is sampled, and drops req for at least one cycle before the next issue.
module nfc_req_port
  import nfc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  input  req_t issue_info,
  input  logic ack,
  output logic req,
  output req_t info,
  output logic ready,
  output logic fire
);

  logic req_q, req_d;
  req_t info_q, info_d;

  // An ack only counts while req is up; a new issue is only taken while req is down, so the
  // cycle after an ack is always idle.
  always_comb begin
    req_d  = req_q;
    info_d = info_q;
    if (req_q && ack) begin
      req_d = 1'b0;
    end else if (!req_q && issue) begin
      req_d  = 1'b1;
      info_d = issue_info;
    end
  end

  // Request and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= 1'b0;
      info_q <= '0;
    end else begin
      req_q  <= req_d;
      info_q <= info_d;
    end
  end

  assign req   = req_q;
  assign info  = info_q;
  assign ready = !req_q;
  assign fire  = req_q && ack;

endmodule

// File: rtl/nfc_copy_scheduler.sv
// Full-device page copy from flash A to flash B through a two-slot ping-pong buffer:
// reads of page n+1 overlap programming of page n, failed programs are retried.
module nfc_copy_scheduler
  import nfc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [PAGE_W:0]   pages_done,
  output logic              rd_req,
  output logic [PAGE_W-1:0] rd_page,
  output logic              rd_slot,
  input  logic              rd_ack,
  output logic              pg_req,
  output logic [PAGE_W-1:0] pg_page,
  output logic              pg_slot,
  input  logic              pg_ack,
  input  logic              pg_fail
);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [CNT_W-1:0]   pages_done_q, pages_done_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   pg_cnt_q, pg_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [1:0]         slot_full_q, slot_full_d;

  logic rd_issue, pg_issue, rd_ready, pg_ready, rd_fire, pg_fire, pg_exhaust;
  req_t rd_next, pg_next, rd_info, pg_info;

  // A page always lives in the slot selected by its LSB.
  assign rd_next = '{page: rd_cnt_q[PAGE_W-1:0], slot: rd_cnt_q[0]};
  assign pg_next = '{page: pg_cnt_q[PAGE_W-1:0], slot: pg_cnt_q[0]};

  assign pg_exhaust = pg_fire && pg_fail && (retry_q >= RETRY_W'(MAX_RETRY));

  nfc_req_port u_rd_port (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (rd_issue),
    .issue_info (rd_next),
    .ack        (rd_ack),
    .req        (rd_req),
    .info       (rd_info),
    .ready      (rd_ready),
    .fire       (rd_fire)
  );

  nfc_req_port u_pg_port (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (pg_issue),
    .issue_info (pg_next),
    .ack        (pg_ack),
    .req        (pg_req),
    .info       (pg_info),
    .ready      (pg_ready),
    .fire       (pg_fire)
  );

  // Next-state logic: request issue, slot bookkeeping, retry accounting and completion status.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    pages_done_d = pages_done_q;
    rd_cnt_d     = rd_cnt_q;
    pg_cnt_d     = pg_cnt_q;
    retry_d      = retry_q;
    slot_full_d  = slot_full_q;
    rd_issue     = 1'b0;
    pg_issue     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_RUN;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          pages_done_d = '0;
          rd_cnt_d     = '0;
          pg_cnt_d     = '0;
          retry_d      = '0;
          slot_full_d  = '0;
        end
      end

      ST_RUN: begin
        rd_issue = rd_ready && (rd_cnt_q < CNT_W'(NUM_PAGES)) &&
                   !slot_full_q[rd_cnt_q[0]] && !pg_exhaust;
        pg_issue = pg_ready && (pg_cnt_q < CNT_W'(NUM_PAGES)) &&
                   slot_full_q[pg_cnt_q[0]];
        if (rd_fire) begin
          slot_full_d[rd_info.slot] = 1'b1;
          rd_cnt_d                  = sat_inc(rd_cnt_q);
        end
        if (pg_fire) begin
          if (!pg_fail) begin
            slot_full_d[pg_info.slot] = 1'b0;
            pg_cnt_d                  = sat_inc(pg_cnt_q);
            pages_done_d              = sat_inc(pages_done_q);
            retry_d                   = '0;
            if (sat_inc(pg_cnt_q) == CNT_W'(NUM_PAGES)) begin
              state_d = ST_FINISH;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else if (pg_exhaust) begin
            state_d = ST_DRAIN;
          end else begin
            retry_d = retry_q + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (!rd_req || rd_fire) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, status and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      pages_done_q <= '0;
      rd_cnt_q     <= '0;
      pg_cnt_q     <= '0;
      retry_q      <= '0;
      slot_full_q  <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      pages_done_q <= pages_done_d;
      rd_cnt_q     <= rd_cnt_d;
      pg_cnt_q     <= pg_cnt_d;
      retry_q      <= retry_d;
      slot_full_q  <= slot_full_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign pages_done = pages_done_q;
  assign rd_page    = rd_info.page;
  assign rd_slot    = rd_info.slot;
  assign pg_page    = pg_info.page;
  assign pg_slot    = pg_info.slot;

endmodule
